// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the falling-edge pipeline hazard controller.
// Holds the multdiv FSM state encoding and the opcode/funct values the datapath decodes.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_BITS_DEF   = 5;
  localparam int MD_TIMEOUT_DEF = 40;
  localparam int CNT_W_DEF      = 6;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } md_state_e;

  // Opcode and funct values behind x_is_load / x_md_start / x_br_taken in the datapath decoder
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_DIV   = 6'b011010;

endpackage

// File: rtl/pipeline_hazard_ctrl_half_cycle_pulse.sv
// Glitch-free half-cycle pulse: armed on the falling edge, cleared on the next rising edge.
// A falling-edge toggle and a rising-edge follower differ only during the first half-cycle.
module half_cycle_pulse (
  input  logic clk,
  input  logic clr,
  input  logic set_i,
  output logic pulse_o
);

  logic tog_q;
  logic ack_q;

  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      tog_q <= 1'b0;
    end else if (set_i) begin
      tog_q <= ~tog_q;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= tog_q;
    end
  end

  // Only one flop changes at a time, so the XOR cannot glitch
  assign pulse_o = tog_q ^ ack_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch control: load-use stall, multdiv wait stall and branch flush.
// state      | meaning
// ST_RUN     | normal flow; load-use stalls and branch flushes are honoured
// ST_MD_WAIT | multdiv in flight; front end frozen, M/W keeps draining
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_BITS   = REG_BITS_DEF,
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [REG_BITS-1:0] d_rs,
  input  logic [REG_BITS-1:0] d_rt,
  input  logic                d_rs_vld,
  input  logic                d_rt_vld,
  input  logic                x_is_load,
  input  logic [REG_BITS-1:0] x_rd,
  input  logic                x_br_taken,
  input  logic                x_md_start,
  input  logic                md_rdy,
  output logic                pc_w_en,
  output logic                fd_w_en,
  output logic                dx_w_en,
  output logic                xm_w_en,
  output logic                mw_w_en,
  output logic                fd_clr,
  output logic                dx_clr,
  output logic                md_busy,
  output logic                md_error
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               md_error_q, md_error_d;

  logic               in_run;
  logic               in_wait;
  logic               rs_hit;
  logic               rt_hit;
  logic               load_use;
  logic               branch;
  logic               stall;
  logic               md_release;

  assign in_run  = (state_q == ST_RUN);
  assign in_wait = (state_q == ST_MD_WAIT);

  assign rs_hit   = d_rs_vld && (d_rs == x_rd);
  assign rt_hit   = d_rt_vld && (d_rt == x_rd);
  assign load_use = in_run && x_is_load && (x_rd != '0) && (rs_hit || rt_hit);
  assign branch   = in_run && x_br_taken;
  // A taken branch flushes the dependent instruction anyway, so no stall is needed
  assign stall    = load_use && !branch;

  assign md_release = in_wait && (md_rdy || (cnt_q == CNT_W'(MD_TIMEOUT - 1)));

  assign pc_w_en = !in_wait && !stall;
  assign fd_w_en = !in_wait && !stall;
  assign dx_w_en = !in_wait;
  assign xm_w_en = !in_wait || md_release;
  assign mw_w_en = 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_error_d = md_error_q;
    case (state_q)
      ST_RUN: begin
        if (x_md_start) begin
          state_d = ST_MD_WAIT;
          cnt_d   = '0;
        end
      end
      ST_MD_WAIT: begin
        if (md_release) begin
          if (!md_rdy) begin
            md_error_d = 1'b1;
          end
          // A new multdiv issued on the release cycle starts a fresh wait
          state_d = x_md_start ? ST_MD_WAIT : ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      md_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_error_q <= md_error_d;
    end
  end

  assign md_busy  = in_wait;
  assign md_error = md_error_q;

  half_cycle_pulse u_fd_clr (
    .clk     (clk),
    .clr     (clr),
    .set_i   (branch),
    .pulse_o (fd_clr)
  );

  half_cycle_pulse u_dx_clr (
    .clk     (clk),
    .clr     (clr),
    .set_i   (branch || load_use),
    .pulse_o (dx_clr)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic against a
// cycle-level behavioural model of stalls, flushes and multdiv waits.
module tb_pipeline_hazard_ctrl;

  localparam int MD_TIMEOUT = 40;

  logic       clk;
  logic       clr;
  logic [4:0] d_rs, d_rt, x_rd;
  logic       d_rs_vld, d_rt_vld, x_is_load, x_br_taken, x_md_start, md_rdy;
  logic       pc_w_en, fd_w_en, dx_w_en, xm_w_en, mw_w_en;
  logic       fd_clr, dx_clr, md_busy, md_error;

  int total;
  int bad;
  int busy_cycles;

  // Model: waiting flag, cycles already spent waiting, sticky error, pending pulses
  bit m_wait;
  int m_waited;
  bit m_err;
  bit m_fd_p;
  bit m_dx_p;

  pipeline_hazard_ctrl dut (
    .clk        (clk),
    .clr        (clr),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_rs_vld   (d_rs_vld),
    .d_rt_vld   (d_rt_vld),
    .x_is_load  (x_is_load),
    .x_rd       (x_rd),
    .x_br_taken (x_br_taken),
    .x_md_start (x_md_start),
    .md_rdy     (md_rdy),
    .pc_w_en    (pc_w_en),
    .fd_w_en    (fd_w_en),
    .dx_w_en    (dx_w_en),
    .xm_w_en    (xm_w_en),
    .mw_w_en    (mw_w_en),
    .fd_clr     (fd_clr),
    .dx_clr     (dx_clr),
    .md_busy    (md_busy),
    .md_error   (md_error)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit ld, input logic [4:0] rd, input logic [4:0] rs,
                        input logic [4:0] rt, input bit rsv, input bit rtv,
                        input bit br, input bit ms, input bit rdy);
    x_is_load  = ld;
    x_rd       = rd;
    d_rs       = rs;
    d_rt       = rt;
    d_rs_vld   = rsv;
    d_rt_vld   = rtv;
    x_br_taken = br;
    x_md_start = ms;
    md_rdy     = rdy;
  endtask

  task automatic idle_in();
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    m_wait   = 0;
    m_waited = 0;
    m_err    = 0;
    m_fd_p   = 0;
    m_dx_p   = 0;
  endtask

  // Called just after a falling edge with this cycle's inputs already applied
  task automatic run_cycle();
    bit         hz, st, rel;
    bit         n_wait, n_err, n_fd, n_dx;
    int         n_waited;
    logic [4:0] exp_w;
    #1;
    if (m_wait) begin
      rel      = md_rdy || (m_waited + 1 >= MD_TIMEOUT);
      exp_w    = {3'b000, rel, 1'b1};
      n_fd     = 0;
      n_dx     = 0;
      n_err    = m_err || (rel && !md_rdy);
      n_wait   = rel ? x_md_start : 1'b1;
      n_waited = rel ? 0 : m_waited + 1;
    end else begin
      hz       = x_is_load && (x_rd != 0) &&
                 ((d_rs_vld && d_rs == x_rd) || (d_rt_vld && d_rt == x_rd));
      st       = hz && !x_br_taken;
      exp_w    = {!st, !st, 3'b111};
      n_fd     = x_br_taken;
      n_dx     = x_br_taken || hz;
      n_err    = m_err;
      n_wait   = x_md_start;
      n_waited = 0;
    end
    chk("w_en", {pc_w_en, fd_w_en, dx_w_en, xm_w_en, mw_w_en}, exp_w);
    @(posedge clk); #1;
    chk("pulses_low_after_rise", {fd_clr, dx_clr}, 2'b00);
    @(negedge clk); #1;
    m_wait   = n_wait;
    m_waited = n_waited;
    m_err    = n_err;
    m_fd_p   = n_fd;
    m_dx_p   = n_dx;
    if (md_busy === 1'b1) busy_cycles++;
    chk("fd_clr", fd_clr, m_fd_p);
    chk("dx_clr", dx_clr, m_dx_p);
    chk("md_busy", md_busy, m_wait);
    chk("md_error", md_error, m_err);
  endtask

  // Asynchronous reset applied mid-cycle, checked before any clock edge
  task automatic async_reset(input string tag);
    idle_in();
    clr = 1'b1;
    #1;
    model_reset();
    chk({tag, "_busy"}, md_busy, 1'b0);
    chk({tag, "_w_en"}, {pc_w_en, fd_w_en, dx_w_en, xm_w_en, mw_w_en}, 5'b11111);
    chk({tag, "_pulses"}, {fd_clr, dx_clr}, 2'b00);
    chk({tag, "_err"}, md_error, 1'b0);
    @(negedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    busy_cycles = 0;
    model_reset();
    idle_in();
    clr = 1'b0;
    #1 clr = 1'b1;
    #1;
    chk("rst_w_en", {pc_w_en, fd_w_en, dx_w_en, xm_w_en, mw_w_en}, 5'b11111);
    chk("rst_busy", md_busy, 1'b0);
    chk("rst_err", md_error, 1'b0);
    chk("rst_pulses", {fd_clr, dx_clr}, 2'b00);
    @(negedge clk); #1;
    clr = 1'b0;

    idle_in(); run_cycle();

    // Load-use on rs, then on rt, then x_rd=0 which must not stall
    set_in(1, 5'd5, 5'd5, 5'd9, 1, 1, 0, 0, 0); run_cycle();
    chk("lu_dx_clr_pulse", dx_clr, 1'b1);
    idle_in(); run_cycle();
    set_in(1, 5'd7, 5'd2, 5'd7, 0, 1, 0, 0, 0); run_cycle();
    set_in(1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0); run_cycle();
    set_in(1, 5'd5, 5'd5, 5'd9, 0, 1, 0, 0, 0); run_cycle();

    // Branch alone, then branch with a concurrent load-use
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0); run_cycle();
    set_in(1, 5'd3, 5'd3, 5'd3, 1, 1, 1, 0, 0); run_cycle();
    chk("br_fd_clr_pulse", fd_clr, 1'b1);
    async_reset("rst_mid_pulse");

    // Multdiv with md_rdy on the 17th waiting cycle
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    busy_cycles = 0;
    run_cycle();
    for (int i = 0; i < 16; i++) begin
      set_in(1, 5'd4, 5'd4, 5'd4, 1, 1, 1, 1, 0);
      run_cycle();
    end
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1); run_cycle();
    chk("md17_busy_cycles", busy_cycles, 17);

    // Timeout: no md_rdy for the full window
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    busy_cycles = 0;
    run_cycle();
    idle_in();
    for (int i = 0; i < MD_TIMEOUT; i++) run_cycle();
    chk("timeout_busy_cycles", busy_cycles, MD_TIMEOUT);
    chk("timeout_error", md_error, 1'b1);
    for (int i = 0; i < 3; i++) run_cycle();
    chk("error_sticky", md_error, 1'b1);

    // Back-to-back: new start on the release cycle, then a full timeout from zero
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0); run_cycle();
    idle_in();
    for (int i = 0; i < 4; i++) run_cycle();
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1); run_cycle();
    chk("b2b_busy", md_busy, 1'b1);
    idle_in();
    busy_cycles = 0;
    for (int i = 0; i < MD_TIMEOUT; i++) run_cycle();
    chk("b2b_busy_cycles", busy_cycles, MD_TIMEOUT - 1);

    // Reset in the middle of a wait
    set_in(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0); run_cycle();
    idle_in();
    for (int i = 0; i < 5; i++) run_cycle();
    async_reset("rst_mid_wait");
    idle_in(); run_cycle();

    for (int i = 0; i < 1500; i++) begin
      set_in(($urandom % 3) == 0, 5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8),
             $urandom % 2, $urandom % 2, ($urandom % 6) == 0,
             ($urandom % 10) == 0, ($urandom % 20) == 0);
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
